// File: rtl/arvi_bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM states, AMO funct7 codes, id width helper.
// The optional atomic-lock feature is built only when ARBITER_LOCK_EN is defined.
package arvi_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // funct7 of the A-extension ops with aq/rl cleared; funct5 sits in [6:2]
    localparam logic [6:0] F7_AMOADD  = 7'b0000000;
    localparam logic [6:0] F7_AMOSWAP = 7'b0000100;
    localparam logic [6:0] F7_LR      = 7'b0001000;
    localparam logic [6:0] F7_SC      = 7'b0001100;
    localparam logic [6:0] F7_AMOXOR  = 7'b0010000;
    localparam logic [6:0] F7_AMOOR   = 7'b0100000;
    localparam logic [6:0] F7_AMOAND  = 7'b0110000;
    localparam logic [6:0] F7_AMOMIN  = 7'b1000000;
    localparam logic [6:0] F7_AMOMAX  = 7'b1010000;
    localparam logic [6:0] F7_AMOMINU = 7'b1100000;
    localparam logic [6:0] F7_AMOMAXU = 7'b1110000;
    localparam logic [6:0] F7_FUNCT5_MASK = 7'b1111100;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_sc(input logic [6:0] op);
        return (op & F7_FUNCT5_MASK) == F7_SC;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping modulo N_PORTS.
// Returns the winner both one-hot and as an index.
module rr_priority_select
    import arvi_bus_pkg::*;
#(
    parameter int N_PORTS = 2
) (
    input  logic [N_PORTS-1:0]          i_req,
    input  logic [id_w(N_PORTS)-1:0]    i_ptr,
    output logic                        o_valid,
    output logic [N_PORTS-1:0]          o_grant_oh,
    output logic [id_w(N_PORTS)-1:0]    o_grant_idx
);

    localparam int ID_W = id_w(N_PORTS);

    int              w_sum;
    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        o_valid     = 1'b0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_sum       = 0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int off = 0; off < N_PORTS; off++) begin
            w_sum = int'(i_ptr) + off;
            if (w_sum >= N_PORTS) begin
                w_sum = w_sum - N_PORTS;
            end
            w_idx = ID_W'(w_sum);
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = w_idx;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-port round-robin arbiter sharing the memory-controller bus among per-hart masters.
// Define ARBITER_LOCK_EN to keep the bus with a master between LR/AMO-read and its release.
module bus_arbiter_rr
    import arvi_bus_pkg::*;
#(
    parameter int N_PORTS      = 2,
    parameter int XLEN         = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_PORTS-1:0]          i_bus_en,
    input  logic [N_PORTS-1:0]          i_wr_en,
    input  logic [N_PORTS*XLEN-1:0]     i_wr_data,
    input  logic [N_PORTS*XLEN-1:0]     i_addr,
    input  logic [N_PORTS*4-1:0]        i_byte_en,
    input  logic [N_PORTS-1:0]          i_atomic,
    input  logic [N_PORTS*7-1:0]        i_operation,
    output logic [N_PORTS-1:0]          o_ack,
    output logic [XLEN-1:0]             o_rd_data,
    input  logic                        i_ack,
    input  logic [XLEN-1:0]             i_rd_data,
    output logic                        o_bus_en,
    output logic                        o_wr_en,
    output logic [XLEN-1:0]             o_wr_data,
    output logic [XLEN-1:0]             o_addr,
    output logic [3:0]                  o_byte_en,
    output logic                        o_atomic,
    output logic [6:0]                  o_operation,
    output logic [id_w(N_PORTS)-1:0]    o_id
);

    localparam int ID_W = id_w(N_PORTS);

    if (N_PORTS < 2) begin : g_bad_ports
        $error("bus_arbiter_rr: N_PORTS must be >= 2");
    end
    if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 31) begin : g_bad_timeout
        $error("bus_arbiter_rr: LOCK_TIMEOUT must fit the 5-bit lock counter");
    end

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant;
    logic [N_PORTS-1:0]  r_grant_oh;
`ifdef ARBITER_LOCK_EN
    logic [4:0]          r_lock_cnt;
`endif

    logic                w_sel_valid;
    logic [N_PORTS-1:0]  w_sel_oh;
    logic [ID_W-1:0]     w_sel_idx;
    logic [ID_W-1:0]     w_next_ptr;
    logic                w_busy;
    logic                w_wr_en;
    logic [XLEN-1:0]     w_wr_data;
    logic [XLEN-1:0]     w_addr;
    logic [3:0]          w_byte_en;
    logic                w_atomic;
    logic [6:0]          w_operation;

    rr_priority_select #(
        .N_PORTS     (N_PORTS)
    ) u_select (
        .i_req       (i_bus_en),
        .i_ptr       (r_ptr),
        .o_valid     (w_sel_valid),
        .o_grant_oh  (w_sel_oh),
        .o_grant_idx (w_sel_idx)
    );

    assign w_next_ptr = (r_grant == ID_W'(N_PORTS - 1)) ? '0 : r_grant + ID_W'(1);
    assign w_busy     = (r_state == ST_BUSY);

    always_comb begin
        w_wr_en     = i_wr_en[r_grant];
        w_wr_data   = i_wr_data[int'(r_grant)*XLEN +: XLEN];
        w_addr      = i_addr[int'(r_grant)*XLEN +: XLEN];
        w_byte_en   = i_byte_en[int'(r_grant)*4 +: 4];
        w_atomic    = i_atomic[r_grant];
        w_operation = i_operation[int'(r_grant)*7 +: 7];
    end

    // Downstream fields are only driven while a transaction is in flight
    assign o_bus_en    = w_busy;
    assign o_wr_en     = w_busy & w_wr_en;
    assign o_wr_data   = w_busy ? w_wr_data : '0;
    assign o_addr      = w_busy ? w_addr : '0;
    assign o_byte_en   = w_busy ? w_byte_en : '0;
    assign o_atomic    = w_busy & w_atomic;
    assign o_operation = w_busy ? w_operation : '0;
    assign o_ack       = (w_busy && i_ack) ? r_grant_oh : '0;
    assign o_rd_data   = (w_busy && i_ack) ? i_rd_data : '0;
    assign o_id        = r_grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_oh <= '0;
`ifdef ARBITER_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_grant    <= w_sel_idx;
                        r_grant_oh <= w_sel_oh;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_ack) begin
`ifdef ARBITER_LOCK_EN
                        if (w_atomic && !is_sc(w_operation)) begin
                            r_state    <= ST_LOCKED;
                            r_lock_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_next_ptr;
                        end
`else
                        r_state <= ST_IDLE;
                        r_ptr   <= w_next_ptr;
`endif
                    end
                end
`ifdef ARBITER_LOCK_EN
                // Only the lock owner may proceed; silence from it eventually frees the bus
                ST_LOCKED: begin
                    if (i_bus_en[r_grant]) begin
                        r_state <= ST_BUSY;
                    end else if (r_lock_cnt == 5'(LOCK_TIMEOUT - 1)) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_next_ptr;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 5'd1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
